usadd_multi: RTL and testbench

//   N-input scaled adder for unipolar/bipolar stochastic bitstreams: oC = sum(iA[i]) / NUM_IN.

---
 rtl/usadd_pkg.sv | 23 ++
 rtl/usadd_popcount.sv | 46 ++++
 rtl/usadd_multi.sv | 119 +++++++++++
 tb/tb_usadd_multi.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/usadd_pkg.sv
// Shared sizing helpers for the stochastic scaled adder.
// Widths are derived from NUM_IN so any channel count (not only powers of two) works.
package usadd_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator width: residue (< NUM_IN) plus a popcount (<= NUM_IN) must fit.
    function automatic int unsigned acc_w(input int unsigned num_in);
        return clog2(2 * num_in);
    endfunction

    function automatic int unsigned pc_w(input int unsigned num_in);
        return clog2(num_in + 1);
    endfunction

endpackage

// File: rtl/usadd_popcount.sv
// Stage 1 of the scaled adder: registered popcount of the masked input bits.
// Idle or cleared cycles register a zero count so the accumulator sees no stale data.
module usadd_popcount
    import usadd_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned PCW = pc_w(NUM_IN)
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iClr,
    input  logic              iEn,
    input  logic [NUM_IN-1:0] iA,
    input  logic [NUM_IN-1:0] iMask,
    output logic [PCW-1:0]    oPc,
    output logic              oV
);

    logic [NUM_IN-1:0] masked;
    logic [PCW-1:0]    pc_d, pc_q;
    logic              v_d, v_q;

    always_comb begin
        masked = iA & iMask;
        pc_d   = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            pc_d = pc_d + PCW'(masked[i]);
        end
        if (!iEn || iClr) pc_d = '0;
        v_d = iEn & ~iClr;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            pc_q <= '0;
            v_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            v_q  <= v_d;
        end
    end

    assign oPc = pc_q;
    assign oV  = v_q;

endmodule

// File: rtl/usadd_multi.sv
// N-input scaled adder for stochastic bitstreams: oC = sum(iA & iMask) / NUM_IN,
// with a windowed ones-counter giving a binary estimate of the output stream.
module usadd_multi
    import usadd_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned CNTW   = 8
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iClr,
    input  logic              iEn,
    input  logic [NUM_IN-1:0] iA,
    input  logic [NUM_IN-1:0] iMask,
    output logic              oC,
    output logic              oValid,
    output logic [CNTW:0]     oCnt,
    output logic              oDone
);

    localparam int unsigned ACC_W = acc_w(NUM_IN);
    localparam int unsigned PCW   = pc_w(NUM_IN);
    localparam int unsigned OW    = CNTW + 1;
    localparam logic [ACC_W-1:0] DIV = ACC_W'(NUM_IN);

    logic [PCW-1:0]   pc;
    logic             v1;
    logic [ACC_W-1:0] sum;

    logic [ACC_W-1:0] acc_d, acc_q;
    logic             c_d, c_q;
    logic             valid_d, valid_q;
    logic [CNTW-1:0]  win_d, win_q;
    logic [OW-1:0]    ones_d, ones_q;
    logic [OW-1:0]    cnt_d, cnt_q;
    logic             done_d, done_q;

    usadd_popcount #(
        .NUM_IN (NUM_IN)
    ) u_popcount (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iClr  (iClr),
        .iEn   (iEn),
        .iA    (iA),
        .iMask (iMask),
        .oPc   (pc),
        .oV    (v1)
    );

    always_comb begin
        sum     = acc_q + ACC_W'(pc);
        acc_d   = acc_q;
        c_d     = 1'b0;
        valid_d = 1'b0;
        win_d   = win_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (v1) begin
            valid_d = 1'b1;
            if (sum >= DIV) begin
                c_d   = 1'b1;
                acc_d = sum - DIV;
            end else begin
                acc_d = sum;
            end
        end

        // Window bookkeeping runs on the registered output, one cycle behind oC.
        if (valid_q) begin
            win_d = win_q + CNTW'(1);
            if (win_q == '1) begin
                cnt_d  = ones_q + OW'(c_q);
                done_d = 1'b1;
                ones_d = '0;
            end else begin
                ones_d = ones_q + OW'(c_q);
            end
        end

        if (iClr) begin
            acc_d   = '0;
            c_d     = 1'b0;
            valid_d = 1'b0;
            win_d   = '0;
            ones_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            acc_q   <= '0;
            c_q     <= 1'b0;
            valid_q <= 1'b0;
            win_q   <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            win_q   <= win_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign oC     = c_q;
    assign oValid = valid_q;
    assign oCnt   = cnt_q;
    assign oDone  = done_q;

endmodule

// File: tb/tb_usadd_multi.sv
// Directed bench for usadd_multi: a 4-input and a 3-input instance, window length 256.
module tb_usadd_multi;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr, en;
    logic [3:0] a4, m4;
    logic [2:0] a3, m3;

    logic       c4, v4, d4;
    logic [8:0] cnt4;
    logic       c3, v3, d3;
    logic [8:0] cnt3;

    bit         sel3;
    logic       oc, ov, od;
    logic [8:0] ocnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    usadd_multi #(.NUM_IN(4), .CNTW(8)) dut4 (
        .iClk(clk), .iRstN(rst_n), .iClr(clr), .iEn(en), .iA(a4), .iMask(m4),
        .oC(c4), .oValid(v4), .oCnt(cnt4), .oDone(d4)
    );

    usadd_multi #(.NUM_IN(3), .CNTW(8)) dut3 (
        .iClk(clk), .iRstN(rst_n), .iClr(clr), .iEn(en), .iA(a3), .iMask(m3),
        .oC(c3), .oValid(v3), .oCnt(cnt3), .oDone(d3)
    );

    always_comb begin
        oc   = sel3 ? c3   : c4;
        ov   = sel3 ? v3   : v4;
        od   = sel3 ? d3   : d4;
        ocnt = sel3 ? cnt3 : cnt4;
    end

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        en  = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Drive iEn (constant or toggling) until oDone; bits on the oDone cycle belong to the next window.
    task automatic run_window(input bit toggle, input int unsigned maxc, input int unsigned cnt_init,
                              output int unsigned vb, output int unsigned ones,
                              output logic [7:0] pat, output logic [5:0] vh,
                              output int unsigned cyc, output bit timeout, output bit cnt_moved);
        vb = 0; ones = 0; pat = '0; vh = '0; cyc = 0; timeout = 1'b1; cnt_moved = 1'b0;
        for (int unsigned c = 1; c <= maxc; c++) begin
            en = toggle ? ((c & 1) == 1) : 1'b1;
            step();
            cyc = c;
            if (c <= 6) vh[c-1] = ov;
            if (od) begin
                timeout = 1'b0;
                break;
            end
            if (ov) begin
                if (vb < 8) pat[vb] = oc;
                vb++;
                ones += int'(oc);
            end
            if (ocnt !== 9'(cnt_init)) cnt_moved = 1'b1;
        end
    endtask

    int unsigned vb, ones, cyc, seen;
    logic [7:0]  pat;
    logic [5:0]  vh;
    bit          tmo, moved;

    initial begin
        rst_n = 1'b0; clr = 1'b0; en = 1'b0;
        a4 = '0; m4 = 4'hF; a3 = '0; m3 = 3'h7; sel3 = 1'b0;

        #12;
        check("rst_oc",    32'(c4),   0);
        check("rst_valid", 32'(v4),   0);
        check("rst_cnt",   32'(cnt4), 0);
        check("rst_done",  32'(d4),   0);
        check("rst_cnt3",  32'(cnt3), 0);
        rst_n = 1'b1;

        // 1: all ones -> every valid bit is 1
        a4 = 4'hF;
        do_clear();
        run_window(1'b0, 600, 0, vb, ones, pat, vh, cyc, tmo, moved);
        check("t1_timeout", 32'(tmo), 0);
        check("t1_cnt",     32'(cnt4), 256);
        check("t1_vbits",   vb, 256);
        check("t1_ones",    ones, 256);
        check("t1_pat",     32'(pat), 32'hFF);
        check("t1_vhist",   32'(vh), 32'h3E);
        check("t1_cyc",     cyc, 258);

        // 2: one active channel -> 1 in 4
        a4 = 4'b0001;
        do_clear();
        run_window(1'b0, 600, 0, vb, ones, pat, vh, cyc, tmo, moved);
        check("t2_timeout", 32'(tmo), 0);
        check("t2_cnt",     32'(cnt4), 64);
        check("t2_pat",     32'(pat), 32'h88);
        check("t2_vbits",   vb, 256);

        // 3: non power-of-two divisor, 2 of 3 -> 0,1,1
        sel3 = 1'b1;
        a3   = 3'b011;
        do_clear();
        run_window(1'b0, 600, 0, vb, ones, pat, vh, cyc, tmo, moved);
        check("t3_timeout", 32'(tmo), 0);
        check("t3_cnt",     32'(cnt3), 170);
        check("t3_pat",     32'(pat), 32'hB6);
        check("t3_vbits",   vb, 256);
        sel3 = 1'b0;

        // 4: masked channels count as zero, divisor unchanged
        a4 = 4'hF;
        m4 = 4'b0011;
        do_clear();
        run_window(1'b0, 600, 0, vb, ones, pat, vh, cyc, tmo, moved);
        check("t4_timeout", 32'(tmo), 0);
        check("t4_cnt",     32'(cnt4), 128);
        check("t4_pat",     32'(pat), 32'hAA);
        m4 = 4'hF;

        // 5: gapped input; window spans 256 valid bits, not 256 cycles
        a4 = 4'b0001;
        do_clear();
        run_window(1'b1, 1200, 0, vb, ones, pat, vh, cyc, tmo, moved);
        check("t5_timeout", 32'(tmo), 0);
        check("t5_cnt",     32'(cnt4), 64);
        check("t5_vbits",   vb, 256);
        check("t5_vhist",   32'(vh), 32'h2A);
        check("t5_pat",     32'(pat), 32'h88);
        check("t5_cyc",     cyc, 513);

        // 6: clear with iEn at valid bit 100, then async reset mid-window
        en = 1'b1;
        seen = 0;
        for (int unsigned c = 0; c < 300 && seen < 100; c++) begin
            step();
            if (ov) seen++;
        end
        check("t6_reach100", seen, 100);
        check("t6_held",     32'(cnt4), 64);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t6_clr_oc",    32'(c4),   0);
        check("t6_clr_valid", 32'(v4),   0);
        check("t6_clr_done",  32'(d4),   0);
        check("t6_clr_cnt",   32'(cnt4), 0);
        step();
        check("t6_gap_valid", 32'(v4), 0);
        step();
        check("t6_first_valid", 32'(v4), 1);
        check("t6_b1", 32'(c4), 0);
        step(); check("t6_b2", 32'(c4), 0);
        step(); check("t6_b3", 32'(c4), 0);
        step(); check("t6_b4", 32'(c4), 1);
        for (int unsigned c = 0; c < 46; c++) step();
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_oc",    32'(c4),   0);
        check("t6_rst_valid", 32'(v4),   0);
        check("t6_rst_cnt",   32'(cnt4), 0);
        check("t6_rst_done",  32'(d4),   0);
        #1;
        rst_n = 1'b1;
        run_window(1'b0, 600, 0, vb, ones, pat, vh, cyc, tmo, moved);
        check("t6_timeout", 32'(tmo), 0);
        check("t6_cnt_hold0", 32'(moved), 0);
        check("t6_cnt",     32'(cnt4), 64);
        check("t6_pat",     32'(pat), 32'h88);
        check("t6_vbits",   vb, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
